// File: rtl/iob_ibus_dbus_merge.sv
// ============================================================================
// Module   : iob_ibus_dbus_merge
// Purpose  : Round-robin merge of CPU ibus/dbus onto one native memory port,
//            with a per-transaction watchdog that forces completion on no ack.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module iob_ibus_dbus_merge #(
  parameter  int ADDR_W  = 32,
  parameter  int DATA_W  = 32,
  parameter  int TIMEOUT = 1024,
  parameter  int TO_W    = 11,
  localparam int STRB_W  = DATA_W / 8,
  localparam int REQ_W   = 1 + ADDR_W + DATA_W + STRB_W,
  localparam int RESP_W  = DATA_W + 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [REQ_W-1:0]  ibus_req,
  output logic [RESP_W-1:0] ibus_resp,
  input  logic [REQ_W-1:0]  dbus_req,
  output logic [RESP_W-1:0] dbus_resp,
  output logic [REQ_W-1:0]  mem_req,
  input  logic [RESP_W-1:0] mem_resp,
  output logic              timeout_err,
  output logic              grant_d
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  localparam logic [TO_W-1:0] C_TO_LAST = TO_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              prio_q,  prio_d;
  logic [TO_W-1:0]   cnt_q,   cnt_d;
  logic              err_q,   err_d;

  logic              ibus_v, dbus_v;
  logic              mem_rdy;
  logic [DATA_W-1:0] mem_rdata;
  logic              wd_fire;
  logic [RESP_W-1:0] resp_sel;

  assign ibus_v    = ibus_req[REQ_W-1];
  assign dbus_v    = dbus_req[REQ_W-1];
  assign mem_rdy   = mem_resp[0];
  assign mem_rdata = mem_resp[RESP_W-1:1];
  assign wd_fire   = (TIMEOUT != 0) && (cnt_q == C_TO_LAST);

  assign timeout_err = err_q;
  assign grant_d     = owner_q;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    prio_d    = prio_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    mem_req   = '0;
    ibus_resp = '0;
    dbus_resp = '0;
    resp_sel  = '0;

    case (state_q)
      S_IDLE: begin
        if (ibus_v && dbus_v) begin
          owner_d = prio_q;
          prio_d  = ~prio_q;
          state_d = S_BUSY;
        end else if (ibus_v) begin
          owner_d = 1'b0;
          prio_d  = 1'b1;
          state_d = S_BUSY;
        end else if (dbus_v) begin
          owner_d = 1'b1;
          prio_d  = 1'b0;
          state_d = S_BUSY;
        end
      end

      S_BUSY: begin
        // Valid comes from the state so a master dropping valid early still completes.
        mem_req = {1'b1, owner_q ? dbus_req[REQ_W-2:0] : ibus_req[REQ_W-2:0]};
        if (mem_rdy) begin
          resp_sel = {mem_rdata, 1'b1};
          state_d  = S_IDLE;
          cnt_d    = '0;
        end else if (wd_fire) begin
          resp_sel = {{DATA_W{1'b0}}, 1'b1};
          err_d    = 1'b1;
          state_d  = S_IDLE;
          cnt_d    = '0;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (owner_q) dbus_resp = resp_sel;
        else         ibus_resp = resp_sel;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_iob_ibus_dbus_merge.sv
// ============================================================================
// Module   : tb_iob_ibus_dbus_merge
// Purpose  : Directed self-checking bench for iob_ibus_dbus_merge (TIMEOUT=8).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_iob_ibus_dbus_merge;

  logic         clk;
  logic         resetn;
  logic [68:0]  ibus_req;
  logic [32:0]  ibus_resp;
  logic [68:0]  dbus_req;
  logic [32:0]  dbus_resp;
  logic [68:0]  mem_req;
  logic [32:0]  mem_resp;
  logic         timeout_err;
  logic         grant_d;

  // Memory responder: acks after `delay` extra BUSY cycles when enabled.
  logic         mem_en;
  logic         force_rdy;
  int           delay;
  int           mcnt;
  logic [31:0]  mem_rdata;
  logic         mem_valid;

  int           n_chk;
  int           n_err;

  iob_ibus_dbus_merge #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (8),
    .TO_W    (11)
  ) u_dut (
    .clk         (clk),
    .resetn      (resetn),
    .ibus_req    (ibus_req),
    .ibus_resp   (ibus_resp),
    .dbus_req    (dbus_req),
    .dbus_resp   (dbus_resp),
    .mem_req     (mem_req),
    .mem_resp    (mem_resp),
    .timeout_err (timeout_err),
    .grant_d     (grant_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_valid = mem_req[68];
  assign mem_resp  = {mem_rdata, force_rdy | (mem_valid & mem_en & (mcnt == delay))};

  always @(posedge clk) begin
    if (mem_valid && !mem_resp[0]) mcnt <= mcnt + 1;
    else                           mcnt <= 0;
  end

  function automatic logic [68:0] req(input logic v, input logic [31:0] a,
                                      input logic [31:0] d, input logic [3:0] s);
    return {v, a, d, s};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    resetn = 1'b0; ibus_req = '0; dbus_req = '0;
    mem_en = 1'b0; force_rdy = 1'b0; delay = 0; mem_rdata = '0;
    tick(); tick();
    chk("rst_mem_req",   mem_req,     0);
    chk("rst_ibus_resp", ibus_resp,   0);
    chk("rst_dbus_resp", dbus_resp,   0);
    chk("rst_grant",     grant_d,     0);
    chk("rst_err",       timeout_err, 0);
    resetn = 1'b1;
    tick();

    // Simultaneous requests: I, D, I, D
    mem_en = 1'b1; delay = 0; mem_rdata = 32'h1111_0001;
    for (int p = 0; p < 2; p++) begin
      ibus_req = req(1'b1, 32'h10, 32'h0, 4'h0);
      dbus_req = req(1'b1, 32'h20, 32'h0, 4'h0);
      chk("rr_idle_mem", mem_req, 0);
      tick();
      chk("rr_grant_i",  grant_d, 0);
      chk("rr_mem_i",    mem_req, req(1'b1, 32'h10, 32'h0, 4'h0));
      chk("rr_iresp",    ibus_resp, {32'h1111_0001, 1'b1});
      chk("rr_dresp_0",  dbus_resp, 0);
      ibus_req = '0;
      tick();
      chk("rr_gap",      mem_req, 0);
      tick();
      chk("rr_grant_d",  grant_d, 1);
      chk("rr_dresp",    dbus_resp, {32'h1111_0001, 1'b1});
      chk("rr_iresp_0",  ibus_resp, 0);
      dbus_req = '0;
      tick();
    end

    // Memory ready while IDLE goes nowhere
    force_rdy = 1'b1; mem_rdata = 32'hCAFE_0000;
    chk("idle_rdy_i", ibus_resp, 0);
    chk("idle_rdy_d", dbus_resp, 0);
    tick();
    chk("idle_rdy_mem", mem_req, 0);
    force_rdy = 1'b0;

    // Single ibus read, ack on the third BUSY cycle
    mem_rdata = 32'hDEAD_BEEF; delay = 2;
    ibus_req = req(1'b1, 32'h100, 32'h0, 4'h0);
    chk("rd_req_cycle", mem_req, 0);
    tick();
    chk("rd_mem_req", mem_req, req(1'b1, 32'h100, 32'h0, 4'h0));
    chk("rd_wait1",   ibus_resp, 0);
    tick();
    chk("rd_wait2",   ibus_resp, 0);
    tick();
    chk("rd_resp",    ibus_resp, {32'hDEAD_BEEF, 1'b1});
    chk("rd_dresp",   dbus_resp, 0);
    ibus_req = '0;
    tick();
    chk("rd_one_cyc", ibus_resp, 0);

    // dbus write fields forwarded verbatim
    delay = 1; mem_rdata = 32'h0BAD_F00D;
    dbus_req = req(1'b1, 32'h2000, 32'h1234_5678, 4'hF);
    tick();
    chk("wr_mem_req", mem_req, req(1'b1, 32'h2000, 32'h1234_5678, 4'hF));
    chk("wr_grant",   grant_d, 1);
    chk("wr_iresp",   ibus_resp, 0);
    chk("wr_dwait",   dbus_resp, 0);
    tick();
    chk("wr_mem_req2", mem_req, req(1'b1, 32'h2000, 32'h1234_5678, 4'hF));
    chk("wr_dresp",   dbus_resp, {32'h0BAD_F00D, 1'b1});
    chk("wr_iresp2",  ibus_resp, 0);
    dbus_req = '0;
    tick();

    // Ack on the 8th BUSY cycle beats the watchdog
    delay = 7; mem_rdata = 32'h55AA_33CC;
    ibus_req = req(1'b1, 32'h300, 32'h0, 4'h0);
    tick();
    for (int i = 1; i < 8; i++) begin
      chk("edge_wait", ibus_resp, 0);
      tick();
    end
    chk("edge_resp", ibus_resp, {32'h55AA_33CC, 1'b1});
    ibus_req = '0;
    tick();
    chk("edge_err", timeout_err, 0);

    // Memory never acks: forced completion after 8 BUSY cycles
    mem_en = 1'b0; mem_rdata = 32'h7777_7777;
    dbus_req = req(1'b1, 32'h400, 32'h0, 4'h0);
    tick();
    for (int i = 1; i < 8; i++) begin
      chk("to_wait", dbus_resp, 0);
      tick();
    end
    chk("to_resp",    dbus_resp, {32'h0, 1'b1});
    chk("to_iresp",   ibus_resp, 0);
    chk("to_err_pre", timeout_err, 0);
    dbus_req = '0;
    tick();
    chk("to_err",     timeout_err, 1);
    chk("to_idle",    mem_req, 0);

    // Sticky flag survives a good transaction
    mem_en = 1'b1; delay = 0; mem_rdata = 32'h1212_1212;
    ibus_req = req(1'b1, 32'h500, 32'h0, 4'h0);
    tick();
    chk("post_resp", ibus_resp, {32'h1212_1212, 1'b1});
    ibus_req = '0;
    tick();
    chk("post_err",  timeout_err, 1);

    // Asynchronous reset mid-transaction
    mem_en = 1'b0;
    dbus_req = req(1'b1, 32'h600, 32'h0, 4'h0);
    tick();
    chk("ar_busy",  mem_req, req(1'b1, 32'h600, 32'h0, 4'h0));
    #2;
    resetn = 1'b0;
    dbus_req = '0;
    #1;
    chk("ar_mem",   mem_req, 0);
    chk("ar_dresp", dbus_resp, 0);
    chk("ar_grant", grant_d, 0);
    chk("ar_err",   timeout_err, 0);
    tick(); tick();
    resetn = 1'b1;
    tick();
    chk("ar_idle",  mem_req, 0);

    mem_en = 1'b1; delay = 1; mem_rdata = 32'h600D_600D;
    dbus_req = req(1'b1, 32'h700, 32'hA5A5_A5A5, 4'h3);
    tick();
    chk("ar_new_grant", grant_d, 1);
    chk("ar_new_mem",   mem_req, req(1'b1, 32'h700, 32'hA5A5_A5A5, 4'h3));
    tick();
    chk("ar_new_resp",  dbus_resp, {32'h600D_600D, 1'b1});
    dbus_req = '0;
    tick();
    chk("ar_new_idle",  mem_req, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/iob_ibus_dbus_merge.md
Name: iob_ibus_dbus_merge

Overview:
- Sits directly downstream of the CPU wrapper and merges its instruction bus and data bus onto one native-interface memory port (shared SRAM/boot ROM path).
- Arbitration is round-robin with the grant locked per transaction.
- A watchdog ends any transaction the memory never acknowledges and flags the error.
- Native bus is valid/ready: the master holds valid, address, wdata and wstrb stable until it sees ready.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; wstrb width is DATA_W/8
- TIMEOUT, 1024, BUSY cycles before forced completion; 0 disables the watchdog
- TO_W, 11, watchdog counter width; must hold TIMEOUT

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- ibus_req  in  REQ_W  instruction request {valid, addr[ADDR_W], wdata[DATA_W], wstrb[DATA_W/8]}, REQ_W=1+ADDR_W+DATA_W+DATA_W/8
- ibus_resp  out  RESP_W  {rdata[DATA_W], ready}, RESP_W=DATA_W+1
- dbus_req  in  REQ_W  data request, same packing
- dbus_resp  out  RESP_W  data response
- mem_req  out  REQ_W  merged request to memory
- mem_resp  in  RESP_W  memory response
- timeout_err  out  1  sticky watchdog flag
- grant_d  out  1  current owner: 0=ibus, 1=dbus; valid only in BUSY

Behaviour:
- Reset (resetn low, async): state=IDLE, grant_d=0, prio=ibus, counter=0, timeout_err=0. All resp outputs 0 and mem_req all 0 combinationally while in IDLE.
- States: IDLE, BUSY.
- IDLE with no valid: stay in IDLE.
- IDLE, exactly one valid: next cycle BUSY, grant to that master.
- IDLE, both valid: grant to prio; then prio flips to the other master.
- IDLE, single grant: prio is set to the other master.
- BUSY, mem ready=1: the granted master's resp = {mem rdata, 1} that cycle. Next state IDLE, counter cleared.
- BUSY, TIMEOUT!=0 and counter==TIMEOUT-1 with no mem ready: the granted master's resp = {0, 1} (forced completion). timeout_err set to 1 and held until reset. Next state IDLE, counter cleared.
- BUSY otherwise: counter+1, stay in BUSY.
- mem_req in BUSY: valid=1 (driven by state, not by the master's valid), addr/wdata/wstrb taken live from the granted master. In IDLE, mem_req=0.
- Non-granted master: resp=0 at all times, including rdata.
- Mem ready seen in IDLE is ignored and routed nowhere.
- Latency: +1 cycle request-to-mem versus a direct connection. At least 1 IDLE cycle between back-to-back transactions.
- The grant never changes inside BUSY. A master dropping valid mid-transaction is a protocol violation; the block still completes the transaction normally.
- If mem ready and the watchdog fire in the same cycle, mem ready wins: real rdata is returned and timeout_err is not set.
- resetn asserted mid-transaction aborts it immediately: IDLE, outputs zeroed, no ready issued.
- Counter never wraps: it is cleared on leaving BUSY and compared against TIMEOUT-1. With TIMEOUT=0 it stays at 0.

Test Plan:
- Single ibus read, addr 0x100, mem returns 0xDEADBEEF with ready 2 cycles after mem valid -> mem valid on cycle 1 after request; ibus_resp={0xDEADBEEF,1} for exactly 1 cycle; dbus_resp=0.
- ibus and dbus valid on the same cycle after reset -> ibus served first, then dbus (1 IDLE gap); repeat both -> ibus first again, since prio alternates: I,D,I,D.
- dbus write, addr 0x2000, wdata 0x12345678, wstrb 0xF -> mem_req carries those exact fields while BUSY; ibus_resp stays 0 throughout.
- TIMEOUT=8, mem never ready -> after 8 BUSY cycles the granted master gets ready with rdata 0; timeout_err=1 and stays 1 across later good transactions.
- TIMEOUT=8, mem ready on the 8th BUSY cycle -> real rdata returned; timeout_err stays 0.
- resetn pulled low while BUSY -> outputs 0 asynchronously; after release, state IDLE and a new request is served normally.
